ctrl_msg_scheduler: RTL and testbench

- Parametrised successor to the per-feature ctrl_* message drivers (e.g. handle_reset_table).
- Collects control-message requests from NUM_CH GameControl sub-handlers (reset-table, move, draw, turn-switch, ...) and arbitrates between them.
- Buffers granted messages in a DEPTH-entry FIFO and issues them one at a time to InterboardCommunication as one-cycle ctrl_en pulses, paced by inter_ready.
- Replaces the ad-hoc OR-ing of per-handler ctrl_* outputs in GameControl_top.

---
 rtl/ctrl_msg_scheduler_if.sv | 35 +++
 rtl/ctrl_msg_scheduler.sv | 161 ++++++++++++++++
 tb/tb_ctrl_msg_scheduler.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_msg_scheduler_if.sv
// rtl/ctrl_msg_scheduler_if.sv - request/issue bundle between GameControl handlers, scheduler and InterboardCommunication
interface ctrl_msg_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                   interboard_rst;
    logic [NUM_CH-1:0]      req;
    logic [22*NUM_CH-1:0]   req_msg;
    logic [NUM_CH-1:0]      ack;
    logic                   inter_ready;
    logic                   ctrl_en;
    logic                   ctrl_move_dir;
    logic [4:0]             ctrl_block_x;
    logic [2:0]             ctrl_block_y;
    logic [3:0]             ctrl_msg_type;
    logic [5:0]             ctrl_card;
    logic [2:0]             ctrl_sel_len;
    logic [CW-1:0]          fifo_count;
    logic                   busy;
    logic                   timeout_err;

    modport master (
        output interboard_rst, req, req_msg, inter_ready,
        input  ack, ctrl_en, ctrl_move_dir, ctrl_block_x, ctrl_block_y,
               ctrl_msg_type, ctrl_card, ctrl_sel_len, fifo_count, busy, timeout_err
    );

    modport slave (
        input  interboard_rst, req, req_msg, inter_ready,
        output ack, ctrl_en, ctrl_move_dir, ctrl_block_x, ctrl_block_y,
               ctrl_msg_type, ctrl_card, ctrl_sel_len, fifo_count, busy, timeout_err
    );
endinterface

// File: rtl/ctrl_msg_scheduler.sv
// rtl/ctrl_msg_scheduler.sv - arbitrates ctrl message requests into a FIFO and issues them paced by inter_ready
module ctrl_msg_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int DEPTH        = 4,
    parameter int ARB_MODE     = 0,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    ctrl_msg_scheduler_if.slave bus
);
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_SEND      = 2'd1;
    localparam logic [1:0] S_WAIT_LOW  = 2'd2;
    localparam logic [1:0] S_WAIT_HIGH = 2'd3;

    logic [1:0]        r_state;
    logic [NUM_CH-1:0] r_ack;
    logic [IW-1:0]     r_rr_ptr;
    logic [21:0]       r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [TW-1:0]     r_to_cnt;
    logic              r_to_err;
    logic              r_ctrl_en;
    logic [21:0]       r_ctrl_msg;

    logic [NUM_CH-1:0] w_elig;
    logic              w_found;
    logic [IW-1:0]     w_win;
    logic [21:0]       w_win_msg;
    logic              w_full;
    logic              w_pop;
    logic              w_push;

    // A channel acked last cycle sits out one cycle so it can drop req before being re-granted.
    always_comb begin
        w_elig  = bus.req & ~r_ack;
        w_found = 1'b0;
        w_win   = '0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (w_elig[i]) begin
                    w_found = 1'b1;
                    w_win   = IW'(i);
                end
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!w_found && w_elig[(int'(r_rr_ptr) + k) % NUM_CH]) begin
                    w_found = 1'b1;
                    w_win   = IW'((int'(r_rr_ptr) + k) % NUM_CH);
                end
            end
        end
    end

    assign w_win_msg = bus.req_msg[int'(w_win) * 22 +: 22];
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0) && bus.inter_ready;
    assign w_push    = w_found && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst && !bus.interboard_rst && w_push) begin
            r_mem[r_wr_ptr] <= w_win_msg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ack      <= '0;
            r_rr_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_to_cnt   <= '0;
            r_to_err   <= 1'b0;
            r_ctrl_en  <= 1'b0;
            r_ctrl_msg <= '0;
        end else if (bus.interboard_rst) begin
            r_state    <= S_IDLE;
            r_ack      <= '0;
            r_rr_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_to_cnt   <= '0;
            r_to_err   <= 1'b0;
            r_ctrl_en  <= 1'b0;
            r_ctrl_msg <= '0;
        end else begin
            r_ack     <= '0;
            r_ctrl_en <= 1'b0;

            if (w_push) begin
                r_ack[w_win] <= 1'b1;
                r_wr_ptr     <= r_wr_ptr + PW'(1);
                r_rr_ptr     <= (w_win == IW'(NUM_CH - 1)) ? '0 : w_win + IW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // ctrl_en is high exactly while in S_SEND; the head entry is latched on the way in.
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state    <= S_SEND;
                        r_ctrl_en  <= 1'b1;
                        r_ctrl_msg <= r_mem[r_rd_ptr];
                    end
                end
                S_SEND: begin
                    r_state  <= S_WAIT_LOW;
                    r_to_cnt <= '0;
                end
                S_WAIT_LOW: begin
                    if (!bus.inter_ready) begin
                        r_state <= S_WAIT_HIGH;
                    end else if (r_to_cnt == TW'(BUSY_TIMEOUT - 1)) begin
                        r_to_err <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (bus.inter_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack           = r_ack;
    assign bus.ctrl_en       = r_ctrl_en;
    assign bus.ctrl_move_dir = r_ctrl_msg[21];
    assign bus.ctrl_block_x  = r_ctrl_msg[20:16];
    assign bus.ctrl_block_y  = r_ctrl_msg[15:13];
    assign bus.ctrl_msg_type = r_ctrl_msg[12:9];
    assign bus.ctrl_card     = r_ctrl_msg[8:3];
    assign bus.ctrl_sel_len  = r_ctrl_msg[2:0];
    assign bus.fifo_count    = r_count;
    assign bus.busy          = (r_count != '0) || (r_state != S_IDLE);
    assign bus.timeout_err   = r_to_err;
endmodule

// File: tb/tb_ctrl_msg_scheduler.sv
// tb/tb_ctrl_msg_scheduler.sv - directed self-checking bench for ctrl_msg_scheduler
module tb_ctrl_msg_scheduler;
    localparam int M_AUTO = 0;
    localparam int M_LOW  = 1;
    localparam int M_HIGH = 2;
    localparam int M_DROP = 3;

    logic clk = 1'b0;
    logic rst;

    ctrl_msg_scheduler_if #(.NUM_CH(4), .DEPTH(4)) bus0 ();
    ctrl_msg_scheduler_if #(.NUM_CH(4), .DEPTH(4)) bus1 ();

    ctrl_msg_scheduler #(.NUM_CH(4), .DEPTH(4), .ARB_MODE(0), .BUSY_TIMEOUT(15)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );
    ctrl_msg_scheduler #(.NUM_CH(4), .DEPTH(4), .ARB_MODE(1), .BUSY_TIMEOUT(15)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    always #5 clk = ~clk;

    logic [21:0] out0;
    assign out0 = {bus0.ctrl_move_dir, bus0.ctrl_block_x, bus0.ctrl_block_y,
                   bus0.ctrl_msg_type, bus0.ctrl_card, bus0.ctrl_sel_len};

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          sent_n, ack_total, rr_n, rdy_mode, t_first;
    bit          prev_en0, prev_en1, ok;
    logic [21:0] sent_log [16];
    int          rr_log [16];
    logic [21:0] pend_msg [4][8];
    int          pend_n [4];
    int          pend_i [4];
    logic [21:0] exp4 [6];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive0();
        logic [87:0] m;
        logic [3:0]  r;
        m = '0;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (pend_i[i] < pend_n[i]) begin
                r[i] = 1'b1;
                m[22*i +: 22] = pend_msg[i][pend_i[i]];
            end
        end
        bus0.req     = r;
        bus0.req_msg = m;
    endtask

    task automatic clear_pend();
        for (int i = 0; i < 4; i++) begin
            pend_n[i] = 0;
            pend_i[i] = 0;
        end
        sent_n    = 0;
        ack_total = 0;
        drive0();
    endtask

    // One cycle: advance to the negedge, log what the DUTs show, then update requesters and ready.
    task automatic tick();
        int idx;
        @(negedge clk);
        cyc++;
        if (bus0.ctrl_en && sent_n < 16) begin
            sent_log[sent_n] = out0;
            sent_n++;
        end
        for (int i = 0; i < 4; i++) begin
            if (bus0.ack[i]) begin
                ack_total++;
                pend_i[i]++;
            end
        end
        if (bus1.ack != 4'b0 && rr_n < 16) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (bus1.ack[i]) idx = i;
            rr_log[rr_n] = idx;
            rr_n++;
        end
        case (rdy_mode)
            M_AUTO:  bus0.inter_ready = ~prev_en0;
            M_LOW:   bus0.inter_ready = 1'b0;
            M_HIGH:  bus0.inter_ready = 1'b1;
            default: if (prev_en0) bus0.inter_ready = 1'b0;
        endcase
        prev_en0 = bus0.ctrl_en;
        bus1.inter_ready = ~prev_en1;
        prev_en1 = bus1.ctrl_en;
        drive0();
    endtask

    task automatic wait_en(input int bound, output bit found);
        found = 1'b0;
        for (int k = 0; k < bound && !found; k++) begin
            tick();
            if (bus0.ctrl_en) found = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        bus0.interboard_rst = 1'b0;
        bus1.interboard_rst = 1'b0;
        bus0.inter_ready = 1'b1;
        bus1.inter_ready = 1'b1;
        bus1.req = '0;
        bus1.req_msg = '0;
        rdy_mode = M_AUTO;
        prev_en0 = 1'b0;
        prev_en1 = 1'b0;
        rr_n = 0;
        clear_pend();

        repeat (3) tick();
        chk("rst_count", bus0.fifo_count, 0);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_ack", bus0.ack, 0);
        chk("rst_en", bus0.ctrl_en, 0);
        chk("rst_terr", bus0.timeout_err, 0);
        chk("rst_fields", out0, 0);
        rst = 1'b1;
        repeat (2) tick();

        // single request on ch2
        clear_pend();
        pend_msg[2][0] = 22'h12345;
        pend_n[2] = 1;
        drive0();
        tick();
        chk("t1_ack", bus0.ack, 4'b0100);
        chk("t1_en_early", bus0.ctrl_en, 0);
        chk("t1_count1", bus0.fifo_count, 1);
        tick();
        chk("t1_en", bus0.ctrl_en, 1);
        chk("t1_msg", out0, 22'h12345);
        chk("t1_card", bus0.ctrl_card, 40);
        chk("t1_blk_x", bus0.ctrl_block_x, 1);
        chk("t1_count0", bus0.fifo_count, 0);
        repeat (4) tick();
        chk("t1_idle_busy", bus0.busy, 0);
        chk("t1_hold", out0, 22'h12345);
        chk("t1_en_low", bus0.ctrl_en, 0);

        // fixed priority: ch0 then ch3
        clear_pend();
        pend_msg[0][0] = 22'h0A0A0;
        pend_n[0] = 1;
        pend_msg[3][0] = 22'h3C3C3;
        pend_n[3] = 1;
        drive0();
        tick();
        chk("t2_ack_ch0", bus0.ack, 4'b0001);
        tick();
        chk("t2_ack_ch3", bus0.ack, 4'b1000);
        chk("t2_en1", bus0.ctrl_en, 1);
        chk("t2_msg1", out0, 22'h0A0A0);
        t_first = cyc;
        wait_en(10, ok);
        chk("t2_en2_seen", ok, 1);
        chk("t2_msg2", out0, 22'h3C3C3);
        chk("t2_spacing", cyc - t_first, 4);
        bus0.interboard_rst = 1'b1;
        tick();
        bus0.interboard_rst = 1'b0;
        chk("t2_flush_busy", bus0.busy, 0);

        // round-robin on the second instance
        rr_n = 0;
        bus1.req_msg = {22'h04444, 22'h03333, 22'h02222, 22'h01111};
        bus1.req = 4'hF;
        for (int k = 0; k < 40 && rr_n < 8; k++) tick();
        bus1.req = 4'h0;
        chk("t3_grants", rr_n >= 8, 1);
        for (int k = 0; k < 8; k++) chk($sformatf("t3_order%0d", k), rr_log[k], k % 4);

        // back-pressure: FIFO fills to 4, ch2/ch3 held
        clear_pend();
        rdy_mode = M_LOW;
        bus0.inter_ready = 1'b0;
        pend_msg[0][0] = 22'h10000;
        pend_msg[0][1] = 22'h10002;
        pend_n[0] = 2;
        pend_msg[1][0] = 22'h20001;
        pend_msg[1][1] = 22'h20003;
        pend_n[1] = 2;
        pend_msg[2][0] = 22'h30004;
        pend_n[2] = 1;
        pend_msg[3][0] = 22'h3F005;
        pend_n[3] = 1;
        exp4[0] = 22'h10000;
        exp4[1] = 22'h20001;
        exp4[2] = 22'h10002;
        exp4[3] = 22'h20003;
        exp4[4] = 22'h30004;
        exp4[5] = 22'h3F005;
        drive0();
        repeat (8) tick();
        chk("t4_acks", ack_total, 4);
        chk("t4_full", bus0.fifo_count, 4);
        chk("t4_ch2_held", pend_i[2], 0);
        chk("t4_ch3_held", pend_i[3], 0);
        chk("t4_none_sent", sent_n, 0);
        rdy_mode = M_AUTO;
        bus0.inter_ready = 1'b1;
        tick();
        chk("t4_en", bus0.ctrl_en, 1);
        chk("t4_full_pushpop", bus0.fifo_count, 4);
        chk("t4_ack_ch2", bus0.ack, 4'b0100);
        for (int k = 0; k < 80 && sent_n < 6; k++) tick();
        chk("t4_sent_n", sent_n, 6);
        for (int k = 0; k < 6; k++) chk($sformatf("t4_sent%0d", k), sent_log[k], exp4[k]);

        // inter_ready stuck high -> timeout
        bus0.interboard_rst = 1'b1;
        tick();
        bus0.interboard_rst = 1'b0;
        clear_pend();
        rdy_mode = M_HIGH;
        pend_msg[1][0] = 22'h15555;
        pend_msg[1][1] = 22'h2AAAA;
        pend_n[1] = 2;
        drive0();
        wait_en(10, ok);
        chk("t5_en1_seen", ok, 1);
        chk("t5_msg1", out0, 22'h15555);
        repeat (15) tick();
        chk("t5_terr_early", bus0.timeout_err, 0);
        tick();
        chk("t5_terr", bus0.timeout_err, 1);
        chk("t5_count", bus0.fifo_count, 1);
        tick();
        chk("t5_en2", bus0.ctrl_en, 1);
        chk("t5_msg2", out0, 22'h2AAAA);
        bus0.interboard_rst = 1'b1;
        tick();
        bus0.interboard_rst = 1'b0;
        chk("t5_flush_terr", bus0.timeout_err, 0);
        chk("t5_flush_count", bus0.fifo_count, 0);
        chk("t5_flush_fields", out0, 0);
        chk("t5_flush_busy", bus0.busy, 0);

        // async reset while parked in S_WAIT_HIGH with 3 entries queued
        clear_pend();
        rdy_mode = M_DROP;
        for (int k = 0; k < 4; k++) pend_msg[0][k] = 22'(k + 1);
        pend_n[0] = 4;
        drive0();
        repeat (10) tick();
        chk("t6_count3", bus0.fifo_count, 3);
        chk("t6_sent1", sent_n, 1);
        chk("t6_busy", bus0.busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_count", bus0.fifo_count, 0);
        chk("t6_rst_busy", bus0.busy, 0);
        chk("t6_rst_en", bus0.ctrl_en, 0);
        chk("t6_rst_fields", out0, 0);
        tick();
        clear_pend();
        rst = 1'b1;
        rdy_mode = M_AUTO;
        bus0.inter_ready = 1'b1;
        repeat (10) tick();
        chk("t6_no_send", sent_n, 0);
        chk("t6_post_count", bus0.fifo_count, 0);
        chk("t6_post_busy", bus0.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
